apb_master_mc: RTL
==================

# apb_master_mc

Parametrised APB4 master with a valid/ready command port, a one-cycle response pulse and an N-way slave-select decoder. It takes single read/write requests from a local controller and runs the IDLE/SETUP/ACCESS protocol. Over the earlier 8-bit single-slave master it adds configurable widths, byte strobes, PSLVERR reporting, address-decoded `psel` and back-to-back transfers. It sits between a CPU/DMA-side request source and the peripheral APB bus segment.

## Interface
- `ADDR_W`, 8: paddr / cmd_addr width.
- `DATA_W`, 8: data width; must be a multiple of 8.
- `NUM_SLV`, 4: number of slaves (2..16). Sets `SEL_W = $clog2(NUM_SLV)`.
- `TIMEOUT_CYC`, 16: maximum ACCESS wait cycles. Used only when `APB_MC_TIMEOUT_EN` is defined.

Ports:
- `pclk`  input  1  bus clock. Everything is rising-edge triggered.
- `prst`  input  1  synchronous active-low reset.
- `cmd_valid`  input  1  request present.
- `cmd_ready`  output  1  request accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_write`  input  1  1 = write, 0 = read.
- `cmd_addr`  input  ADDR_W  target address. The top `SEL_W` bits are the slave index.
- `cmd_wdata`  input  DATA_W  write data.
- `cmd_strb`  input  DATA_W/8  write byte strobes.
- `rsp_valid`  output  1  one-cycle completion pulse.
- `rsp_rdata`  output  DATA_W  read data; 0 for writes and errors.
- `rsp_err`  output  1  slave error, decode error or timeout; valid only with `rsp_valid`.
- `psel`  output  NUM_SLV  one-hot slave select.
- `penable`  output  1  APB enable.
- `pwrite`  output  1  APB direction.
- `paddr`  output  ADDR_W  APB address.
- `pwdata`  output  DATA_W  APB write data.
- `pstrb`  output  DATA_W/8  APB strobes.
- `prdata`  input  DATA_W  read data from the selected slave.
- `pready`  input  1  slave ready.
- `pslverr`  input  1  slave error.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS. Reset forces IDLE.
- **Reset values:** all outputs 0, except `cmd_ready`, which is 1 because it is decoded from IDLE.
- **cmd_ready:** 1 in IDLE. Also 1 in an ACCESS cycle where `pready`=1, or where the timeout fires. 0 otherwise.
- **IDLE + accept:** latch command into `paddr`, `pwrite`, `pwdata` and `pstrb`, then go to SETUP.
  - Reads drive `pstrb`=0.
  - Reads drive `pwdata` with its previous value.
- **IDLE, no accept:** `paddr`, `pwrite`, `pwdata` and `pstrb` hold their last values. `psel`=0, `penable`=0.
- **Decode error (index ≥ NUM_SLV) on accept:** no bus cycle; stay in IDLE. Next cycle: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
- **SETUP:** `psel[index]`=1, `penable`=0. Always goes to ACCESS next cycle.
- **ACCESS:** `psel[index]`=1, `penable`=1. Address, control and data are held stable.
  - `pready`=0: stay in ACCESS.
  - `pready`=1: transfer completes. Next cycle `rsp_valid`=1, `rsp_err`=`pslverr`, `rsp_rdata`=`prdata` for a read without error, else 0.
  - On completion with a command accepted in the same cycle: go straight to SETUP with the new command; `psel` stays high if the index is unchanged.
  - On completion with no accept: go to IDLE.
- **Completion with a decode-error command accepted:** go to IDLE, then issue the error response one cycle after the bus response.
- **Ignored inputs:** `pready`, `pslverr` and `prdata` are ignored outside ACCESS.
- **Reset mid-transfer:** drop `psel` and `penable` immediately at the reset edge. No response is issued for the aborted command.

## Timing
- Command accepted at edge N: SETUP visible N+1, ACCESS N+2.
- With `pready`=1 in the first ACCESS cycle, `rsp_valid` is visible in cycle N+3.
- Each slave wait cycle adds 1 to that latency.
- Back-to-back throughput: one transfer per 2 cycles with zero wait states.
- `rsp_valid` is high for exactly one cycle per accepted command, in acceptance order. There is no backpressure on responses.
- All APB outputs are registered; there is no combinational path from `pready` to any APB output.

## Configuration
- **`APB_MC_TIMEOUT_EN` defined:**
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
  - When the count reaches `TIMEOUT_CYC`, the transfer aborts: `psel` and `penable` drop next cycle, the FSM goes to IDLE (or SETUP if a command is accepted), and `rsp_valid`=1 with `rsp_err`=1 and `rsp_rdata`=0.
- **Not defined:** no counter is built and ACCESS waits indefinitely for `pready`.

## Test plan
- **Reset:** hold `prst`=0 for 3 cycles mid-ACCESS → `psel`=0, `penable`=0, `paddr`=0, no `rsp_valid`, `cmd_ready`=1 after release.
- **Zero-wait write:** write `addr`=0x45 (NUM_SLV=4, index 1), `wdata`=0xA5, `strb`=1, `pready` tied 1 → `psel`=4'b0010 for 2 cycles, `penable` in the 2nd, `pstrb`=1, `rsp_valid` at N+3, `rsp_err`=0.
- **Wait-state read:** read 0xC0; `pready` low for 3 ACCESS cycles, then high with `prdata`=0x3C, `pslverr`=1 → `penable` high 4 cycles, `rsp_rdata`=0, `rsp_err`=1.
- **Back-to-back:** two reads to index 0 with `cmd_valid` held → SETUP follows ACCESS directly, `psel[0]` never drops, two `rsp_valid` pulses 2 cycles apart.
- **Decode error:** NUM_SLV=3, `addr`=0xC0 → no `psel` bit asserted, `rsp_valid`=1 with `rsp_err`=1 one cycle after accept.
- **Timeout (`APB_MC_TIMEOUT_EN`, TIMEOUT_CYC=4):** `pready` stuck 0 → abort after 4 wait cycles, `rsp_err`=1, `rsp_rdata`=0. Without the macro, ACCESS persists for 100 cycles.

Source files
------------

// File: rtl/apb_master_mc_if.sv
// Command, response and APB bus signals of apb_master_mc, bundled for both sides.
// Handshake: a command transfers on a rising pclk edge where cmd_valid and cmd_ready are both
// high; the requester holds cmd_* stable while cmd_valid is high and not yet accepted.
// rsp_valid is a one-cycle pulse with no backpressure.
interface apb_master_mc_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [NUM_SLV-1:0] psel;
    logic               penable;
    logic               pwrite;
    logic [ADDR_W-1:0]  paddr;
    logic [DATA_W-1:0]  pwdata;
    logic [STRB_W-1:0]  pstrb;
    logic [DATA_W-1:0]  prdata;
    logic               pready;
    logic               pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata, pstrb
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata, pstrb
    );
endinterface

// File: rtl/apb_master_mc.sv
// APB4 master: valid/ready command port, one-cycle response pulse, N-way psel decode.
// Optional ACCESS wait timeout is built only when APB_MC_TIMEOUT_EN is defined.
module apb_master_mc #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int NUM_SLV     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            pclk,
    input  logic            prst,
    apb_master_mc_if.master bus,
    output logic [1:0]      dbg_state
);
    localparam int SEL_W  = $clog2(NUM_SLV);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [SEL_W:0]     SLV_LIM = (SEL_W + 1)'(NUM_SLV);
    localparam logic [NUM_SLV-1:0] SEL_ONE = {{(NUM_SLV - 1){1'b0}}, 1'b1};

    if ((DATA_W % 8) != 0 || NUM_SLV < 2 || NUM_SLV > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("apb_master_mc: unsupported parameter set");
    end

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [NUM_SLV-1:0] psel_q;
    logic [NUM_SLV-1:0] psel_nxt;
    logic               penable_q;
    logic               pwrite_q;
    logic [ADDR_W-1:0]  paddr_q;
    logic [DATA_W-1:0]  pwdata_q;
    logic [STRB_W-1:0]  pstrb_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic               err_pend;

    logic [SEL_W-1:0]   cmd_idx;
    logic               idx_ok;
    logic               bus_done;
    logic               timeout;
    logic               xfer_end;
    logic               cmd_ready_c;
    logic               accept;
    logic               acc_ok;
    logic               acc_err;

    assign cmd_idx = bus.cmd_addr[ADDR_W-1 -: SEL_W];
    assign idx_ok  = {1'b0, cmd_idx} < SLV_LIM;

`ifdef APB_MC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Fires on the wait cycle that brings the count up to TIMEOUT_CYC.
    assign timeout = (state == ST_ACCESS) && !bus.pready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge pclk) begin
        if (!prst) begin
            wait_cnt <= '0;
        end else if (state != ST_ACCESS) begin
            wait_cnt <= '0;
        end else if (!bus.pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign bus_done    = (state == ST_ACCESS) && bus.pready;
    assign xfer_end    = bus_done || timeout;
    assign cmd_ready_c = (state == ST_IDLE) || xfer_end;
    assign accept      = bus.cmd_valid && cmd_ready_c;
    assign acc_ok      = accept && idx_ok;
    assign acc_err     = accept && !idx_ok;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (acc_ok) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (xfer_end) state_nxt = acc_ok ? ST_SETUP : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // psel is registered and only changes on a new accept or when the bus goes idle,
    // so it stays high across back-to-back transfers to the same slave.
    always_comb begin
        psel_nxt = psel_q;
        if (acc_ok) begin
            psel_nxt = SEL_ONE << cmd_idx;
        end else if (state_nxt == ST_IDLE) begin
            psel_nxt = '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (!prst) begin
            state     <= ST_IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
        end else begin
            state     <= state_nxt;
            psel_q    <= psel_nxt;
            penable_q <= (state_nxt == ST_ACCESS);
            if (acc_ok) begin
                paddr_q  <= bus.cmd_addr;
                pwrite_q <= bus.cmd_write;
                pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
                if (bus.cmd_write) begin
                    pwdata_q <= bus.cmd_wdata;
                end
            end
        end
    end

    // A bus completion owns the response slot of its edge; a decode error accepted on that
    // same edge is parked in err_pend and answered one cycle later.
    always_ff @(posedge pclk) begin
        if (!prst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_pend    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            if (xfer_end) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= timeout || bus.pslverr;
                if (bus_done && !pwrite_q && !bus.pslverr) begin
                    rsp_rdata_q <= bus.prdata;
                end
                err_pend <= err_pend || acc_err;
            end else if (err_pend || acc_err) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                err_pend    <= err_pend && acc_err;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pstrb     = pstrb_q;
    assign dbg_state     = state;
endmodule
